// File: rtl/emc_port_io.sv
// emc_port_io: 8051-style quasi-bidirectional port (latch SFR, pull-up
// pulse on 0->1 writes, alt-function mux, pad Y synchroniser).
// Ports: clock_i/reset_b_i; sfr_wr_i/sfr_wdata_i/sfr_latch_o latch SFR;
//   pin_o synchronised pin; alt_sel_i/alt_data_i/alt_oe_i alt function;
//   pad_a_o/pad_en_o (en active-low) to pad, pad_y_i from pad;
//   pin_rise_o/pin_fall_o edge pulses, live only with EMC_PORT_EDGE_EN.
module emc_port_io #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int PULLUP_CYCLES = 2
) (
  input  logic             clock_i,
  input  logic             reset_b_i,
  input  logic             sfr_wr_i,
  input  logic [WIDTH-1:0] sfr_wdata_i,
  output logic [WIDTH-1:0] sfr_latch_o,
  output logic [WIDTH-1:0] pin_o,
  input  logic [WIDTH-1:0] alt_sel_i,
  input  logic [WIDTH-1:0] alt_data_i,
  input  logic [WIDTH-1:0] alt_oe_i,
  output logic [WIDTH-1:0] pad_a_o,
  output logic [WIDTH-1:0] pad_en_o,
  input  logic [WIDTH-1:0] pad_y_i,
  output logic [WIDTH-1:0] pin_rise_o,
  output logic [WIDTH-1:0] pin_fall_o
);

  localparam logic [3:0] PU_LOAD = 4'(PULLUP_CYCLES);

  logic [WIDTH-1:0]      latch_q;
  logic [WIDTH-1:0][3:0] cnt_q;
  logic [WIDTH-1:0][3:0] cnt_d;
  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sfr_wr_i && !latch_q[i] && sfr_wdata_i[i])
        cnt_d[i] = PU_LOAD;
      else if (sfr_wr_i && !sfr_wdata_i[i])
        cnt_d[i] = 4'd0;
      else if (cnt_q[i] != 4'd0)
        cnt_d[i] = cnt_q[i] - 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      latch_q <= '1;
      cnt_q   <= '0;
    end else begin
      if (sfr_wr_i)
        latch_q <= sfr_wdata_i;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '1;
    end else begin
      sync_q[0] <= pad_y_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign sfr_latch_o = latch_q;
  assign pin_o       = sync_q[SYNC_STAGES-1];

  // Alt inputs arrive registered from the core, so only they
  // may reach the pads combinationally.
  always_comb begin
    pad_a_o  = '1;
    pad_en_o = '1;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (1'b1)
        alt_sel_i[i]: begin
          pad_a_o[i]  = alt_data_i[i];
          pad_en_o[i] = ~alt_oe_i[i];
        end
        !latch_q[i]: begin
          pad_a_o[i]  = 1'b0;
          pad_en_o[i] = 1'b0;
        end
        (cnt_q[i] != 4'd0): begin
          pad_a_o[i]  = 1'b1;
          pad_en_o[i] = 1'b0;
        end
        default: begin
          pad_a_o[i]  = 1'b1;
          pad_en_o[i] = 1'b1;
        end
      endcase
    end
  end

`ifdef EMC_PORT_EDGE_EN
  logic [WIDTH-1:0] prev_q;

  // prev resets high to match pin_o, so reset exit is pulse-free.
  always_ff @(posedge clock_i or negedge reset_b_i) begin
    if (!reset_b_i)
      prev_q <= '1;
    else
      prev_q <= pin_o;
  end

  assign pin_rise_o = pin_o & ~prev_q;
  assign pin_fall_o = ~pin_o & prev_q;
`else
  assign pin_rise_o = '0;
  assign pin_fall_o = '0;
`endif

endmodule

// File: tb/tb_emc_port_io.sv
// tb_emc_port_io: directed self-checking bench for emc_port_io.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_emc_port_io;

  logic       clock;
  logic       reset_b;
  logic       sfr_wr;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_latch;
  logic [7:0] pin;
  logic [7:0] alt_sel;
  logic [7:0] alt_data;
  logic [7:0] alt_oe;
  logic [7:0] pad_a;
  logic [7:0] pad_en;
  logic [7:0] pad_y;
  logic [7:0] pin_rise;
  logic [7:0] pin_fall;

  int checks = 0;
  int fails  = 0;

`ifdef EMC_PORT_EDGE_EN
  localparam logic [7:0] EXP_FALL = 8'h5A;
`else
  localparam logic [7:0] EXP_FALL = 8'h00;
`endif

  emc_port_io #(
    .WIDTH(8), .SYNC_STAGES(2), .PULLUP_CYCLES(2)
  ) dut (
    .clock_i    (clock),
    .reset_b_i  (reset_b),
    .sfr_wr_i   (sfr_wr),
    .sfr_wdata_i(sfr_wdata),
    .sfr_latch_o(sfr_latch),
    .pin_o      (pin),
    .alt_sel_i  (alt_sel),
    .alt_data_i (alt_data),
    .alt_oe_i   (alt_oe),
    .pad_a_o    (pad_a),
    .pad_en_o   (pad_en),
    .pad_y_i    (pad_y),
    .pin_rise_o (pin_rise),
    .pin_fall_o (pin_fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    sfr_wr    = 1'b1;
    sfr_wdata = d;
    tick();
    sfr_wr    = 1'b0;
  endtask

  task automatic test_reset();
    reset_b  = 1'b0;
    sfr_wr   = 1'b0;
    sfr_wdata = 8'h00;
    alt_sel  = 8'h00;
    alt_data = 8'h00;
    alt_oe   = 8'h00;
    pad_y    = 8'hFF;
    tick(); tick();
    reset_b = 1'b1;
    tick();
    checks++; if (sfr_latch !== 8'hFF) begin fails++;
      $display("FAIL reset_latch got %h exp FF", sfr_latch); end
    checks++; if (pad_en !== 8'hFF) begin fails++;
      $display("FAIL reset_en got %h exp FF", pad_en); end
    checks++; if (pad_a !== 8'hFF) begin fails++;
      $display("FAIL reset_a got %h exp FF", pad_a); end
    checks++; if (pin !== 8'hFF) begin fails++;
      $display("FAIL reset_pin got %h exp FF", pin); end
    checks++; if (pin_rise !== 8'h00) begin fails++;
      $display("FAIL reset_rise got %h exp 00", pin_rise); end
    checks++; if (pin_fall !== 8'h00) begin fails++;
      $display("FAIL reset_fall got %h exp 00", pin_fall); end
  endtask

  task automatic test_pullup();
    wr(8'h00);
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h00) begin fails++;
      $display("FAIL pu_low en %h a %h exp 00/00", pad_en, pad_a); end
    wr(8'h0F);
    checks++; if (sfr_latch !== 8'h0F) begin fails++;
      $display("FAIL pu_latch got %h exp 0F", sfr_latch); end
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h0F) begin fails++;
      $display("FAIL pu_c1 en %h a %h exp 00/0F", pad_en, pad_a); end
    tick();
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h0F) begin fails++;
      $display("FAIL pu_c2 en %h a %h exp 00/0F", pad_en, pad_a); end
    tick();
    checks++; if (pad_en !== 8'h0F || pad_a !== 8'h0F) begin fails++;
      $display("FAIL pu_rel en %h a %h exp 0F/0F", pad_en, pad_a); end
  endtask

  task automatic test_cut();
    wr(8'h00);
    wr(8'h01);
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h01) begin fails++;
      $display("FAIL cut_hi en %h a %h exp 00/01", pad_en, pad_a); end
    wr(8'h00);
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h00) begin fails++;
      $display("FAIL cut_lo en %h a %h exp 00/00", pad_en, pad_a); end
    tick();
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h00) begin fails++;
      $display("FAIL cut_hold en %h a %h exp 00/00", pad_en, pad_a); end
  endtask

  task automatic test_back_to_back();
    wr(8'h01);
    wr(8'h01);
    checks++; if (pad_en !== 8'h00 || pad_a !== 8'h01) begin fails++;
      $display("FAIL b2b_run en %h a %h exp 00/01", pad_en, pad_a); end
    tick();
    checks++; if (pad_en !== 8'h01 || pad_a !== 8'h01) begin fails++;
      $display("FAIL b2b_noext en %h a %h exp 01/01", pad_en, pad_a); end
  endtask

  task automatic test_sync();
    pad_y = 8'hA5;
    tick();
    checks++; if (pin !== 8'hFF) begin fails++;
      $display("FAIL sync_e1 got %h exp FF", pin); end
    tick();
    checks++; if (pin !== 8'hA5) begin fails++;
      $display("FAIL sync_e2 got %h exp A5", pin); end
    checks++; if (pin_fall !== EXP_FALL) begin fails++;
      $display("FAIL sync_fall got %h exp %h", pin_fall, EXP_FALL); end
    checks++; if (pin_rise !== 8'h00) begin fails++;
      $display("FAIL sync_rise got %h exp 00", pin_rise); end
    tick();
    checks++; if (pin_fall !== 8'h00) begin fails++;
      $display("FAIL sync_fall_end got %h exp 00", pin_fall); end
    pad_y = 8'hFF;
    tick(); tick(); tick();
  endtask

  task automatic test_alt();
    wr(8'h00);
    wr(8'hFF);
    tick(); tick();
    alt_sel  = 8'h80;
    alt_oe   = 8'h80;
    alt_data = 8'h00;
    #1;
    checks++; if (pad_en !== 8'h7F || pad_a !== 8'h7F) begin fails++;
      $display("FAIL alt_drv en %h a %h exp 7F/7F", pad_en, pad_a); end
    alt_oe = 8'h00;
    #1;
    checks++; if (pad_en !== 8'hFF || pad_a !== 8'h7F) begin fails++;
      $display("FAIL alt_hiz en %h a %h exp FF/7F", pad_en, pad_a); end
    tick();
    alt_sel = 8'h00;
    tick();
    checks++; if (pad_en !== 8'hFF || pad_a !== 8'hFF) begin fails++;
      $display("FAIL alt_ret en %h a %h exp FF/FF", pad_en, pad_a); end
  endtask

  task automatic test_async_reset();
    wr(8'h00);
    wr(8'hFF);
    checks++; if (pad_en !== 8'h00) begin fails++;
      $display("FAIL ar_pulse en %h exp 00", pad_en); end
    #2;
    reset_b = 1'b0;
    #1;
    checks++; if (pad_en !== 8'hFF || pad_a !== 8'hFF) begin fails++;
      $display("FAIL ar_abort en %h a %h exp FF/FF", pad_en, pad_a); end
    tick();
    reset_b = 1'b1;
    tick();
    checks++; if (pad_en !== 8'hFF) begin fails++;
      $display("FAIL ar_after en %h exp FF", pad_en); end
  endtask

  initial begin
    test_reset();
    test_pullup();
    test_cut();
    test_back_to_back();
    test_sync();
    test_alt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
